// File: rtl/layer_mac_scheduler_if.sv
// layer_mac_scheduler_if: memory read port and result stream of the layer scheduler
interface layer_mac_scheduler_if #(
  parameter int NUM_IN  = 15,
  parameter int NUM_OUT = 32
);
  localparam int KW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
  localparam int WW = NUM_IN * NUM_OUT > 1 ? $clog2(NUM_IN * NUM_OUT) : 1;
  localparam int NW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  logic                 rd_en;
  logic [KW-1:0]        act_addr;
  logic [WW-1:0]        w_addr;
  logic [NW-1:0]        b_addr;
  logic signed [7:0]    act_data;
  logic signed [7:0]    w_data;
  logic signed [7:0]    b_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NW-1:0]        out_idx;
  logic [7:0]           out_data;
  modport master (
    output rd_en, act_addr, w_addr, b_addr, out_valid, out_idx, out_data,
    input  act_data, w_data, b_data, out_ready
  );
  modport slave (
    input  rd_en, act_addr, w_addr, b_addr, out_valid, out_idx, out_data,
    output act_data, w_data, b_data, out_ready
  );
endinterface

// File: rtl/layer_mac_scheduler.sv
// layer_mac_scheduler: one shared signed 8x8 MAC sequencing a fully-connected ReLU layer
module layer_mac_scheduler #(
  parameter int NUM_IN  = 15,
  parameter int NUM_OUT = 32,
  parameter int ACCW    = 20,
  parameter int SHIFT   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  layer_mac_scheduler_if.master m
);
  localparam int KW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
  localparam int WW = NUM_IN * NUM_OUT > 1 ? $clog2(NUM_IN * NUM_OUT) : 1;
  localparam int NW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EMIT, DONE} state_t;
  state_t state, nxt;
  logic [NW-1:0] n;
  logic [KW-1:0] k;
  logic signed [ACCW-1:0] acc, acc_nxt, v;
  logic signed [15:0] prod;
  logic [7:0] sat;
  logic pv, pk0;
  wire last_k = k == KW'(NUM_IN - 1);
  wire last_n = n == NW'(NUM_OUT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    busy = state != IDLE;
    done = state == DONE;
    m.rd_en = state == ISSUE;
    m.out_valid = state == EMIT;
    m.act_addr = k;
    m.b_addr = n;
    m.w_addr = WW'(int'(n) * NUM_IN + int'(k));
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = start ? ISSUE : IDLE;
        ISSUE:   nxt = last_k ? DRAIN : ISSUE;
        DRAIN:   nxt = EMIT;
        EMIT:    nxt = m.out_ready ? (last_n ? DONE : ISSUE) : EMIT;
        default: nxt = IDLE;
      endcase
  end
  // pk0 marks the first product of a neuron, which is seeded with the bias instead of acc
  assign prod = m.act_data * m.w_data;
  assign acc_nxt = (pk0 ? ACCW'(m.b_data) : acc) + ACCW'(prod);
  assign v = acc_nxt >>> SHIFT;
  assign sat = v[ACCW-1] ? 8'd0 : (v > ACCW'(127) ? 8'd127 : v[7:0]);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      n <= '0;
      k <= '0;
      acc <= '0;
      pv <= 1'b0;
      pk0 <= 1'b0;
      m.out_data <= '0;
      m.out_idx <= '0;
    end else begin
      pv <= m.rd_en && !abort;
      pk0 <= k == '0;
      if (state == IDLE) begin
        n <= '0;
        k <= '0;
        acc <= '0;
      end else begin
        if (pv) acc <= acc_nxt;
        if (state == ISSUE) k <= last_k ? '0 : k + 1'b1;
        if (state == DRAIN) begin
          m.out_data <= sat;
          m.out_idx <= n;
        end
        if (state == EMIT && m.out_ready && !last_n) n <= n + 1'b1;
      end
    end
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// tb_layer_mac_scheduler: directed vectors with a queue scoreboard checked by output monitors
module tb_layer_mac_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b, start_c, abort_a, abort_b, abort_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  int total = 0, bad = 0;
  int dn_a = 0, dn_b = 0, dn_c = 0, hs_a = 0;
  int qa[$], qb[$], qc[$];
  logic signed [7:0] act [3];
  logic signed [7:0] wm [6];
  logic signed [7:0] bm [2];
  logic signed [7:0] act_b [15];
  logic signed [7:0] w_b [480];
  logic signed [7:0] b_b [32];

  always #5 clk = ~clk;

  layer_mac_scheduler_if #(.NUM_IN(3), .NUM_OUT(2)) ia ();
  layer_mac_scheduler_if #(.NUM_IN(15), .NUM_OUT(32)) ib ();
  layer_mac_scheduler_if #(.NUM_IN(3), .NUM_OUT(1)) ic ();

  layer_mac_scheduler #(.NUM_IN(3), .NUM_OUT(2)) ua (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .m(ia));
  layer_mac_scheduler ub (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .m(ib));
  layer_mac_scheduler #(.NUM_IN(3), .NUM_OUT(1), .SHIFT(8)) uc (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_c),
    .busy(busy_c), .done(done_c), .m(ic));

  always @(posedge clk) begin
    if (ia.rd_en) begin
      ia.act_data <= act[ia.act_addr];
      ia.w_data <= wm[ia.w_addr];
      ia.b_data <= bm[ia.b_addr];
    end
    if (ib.rd_en) begin
      ib.act_data <= act_b[ib.act_addr];
      ib.w_data <= w_b[ib.w_addr];
      ib.b_data <= b_b[ib.b_addr];
    end
    if (ic.rd_en) begin
      ic.act_data <= act[ic.act_addr];
      ic.w_data <= wm[ic.w_addr];
      ic.b_data <= bm[ic.b_addr];
    end
  end

  task automatic chk(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask

  task automatic chk_out(string nm, ref int q[$], input int idx, input int data);
    int e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s extra output idx=%0d data=%0d exp=none", nm, idx, data);
    end else begin
      e = q.pop_front();
      chk({nm, "_idx"}, idx, e >> 8);
      chk({nm, "_data"}, data, e & 255);
    end
  endtask

  task automatic wait_for(string nm, ref int cnt, input int target);
    int t = 0;
    while (cnt < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, int'(cnt >= target), 1);
  endtask

  task automatic go(input bit a, input bit b, input bit c);
    start_a = a;
    start_b = b;
    start_c = c;
    @(negedge clk);
    start_a = 0;
    start_b = 0;
    start_c = 0;
  endtask

  always @(negedge clk) begin
    if (done_a) dn_a++;
    if (done_b) dn_b++;
    if (done_c) dn_c++;
    if (reset && ia.out_valid && ia.out_ready) begin
      hs_a++;
      chk_out("a_out", qa, int'(ia.out_idx), int'(ia.out_data));
    end
    if (reset && ib.out_valid && ib.out_ready) chk_out("b_out", qb, int'(ib.out_idx), int'(ib.out_data));
    if (reset && ic.out_valid && ic.out_ready) chk_out("c_out", qc, int'(ic.out_idx), int'(ic.out_data));
  end

  initial begin
    int d0, h0, s, r;
    reset = 1;
    {start_a, start_b, start_c, abort_a, abort_b, abort_c} = '0;
    ia.out_ready = 1;
    ib.out_ready = 1;
    ic.out_ready = 1;
    act = '{8'sd10, 8'sd20, -8'sd5};
    wm = '{8'sd2, 8'sd1, 8'sd4, -8'sd3, -8'sd3, -8'sd3};
    bm = '{-8'sd1, 8'sd0};
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rd_en", ia.rd_en, 0);
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_data", ia.out_data, 0);
    chk("rst_idx", ia.out_idx, 0);
    chk("rst_w_addr", ia.w_addr, 0);
    chk("rst_b_addr", ia.b_addr, 0);
    reset = 1;
    @(negedge clk);
    // basic two-neuron layer with cycle-exact timing
    qa.push_back(19);
    qa.push_back(256);
    go(1, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("t1_valid_c%0d", c), ia.out_valid, int'(c == 5 || c == 10));
      chk($sformatf("t1_done_c%0d", c), done_a, int'(c == 11));
      chk($sformatf("t1_busy_c%0d", c), busy_a, int'(c < 12));
      if (c < 12) @(negedge clk);
    end
    // backpressure on neuron 0
    qa.push_back(19);
    qa.push_back(256);
    ia.out_ready = 0;
    d0 = dn_a;
    go(1, 0, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", ia.out_valid, 1);
      chk("t2_data", ia.out_data, 19);
      chk("t2_idx", ia.out_idx, 0);
      chk("t2_rd_en", ia.rd_en, 0);
      @(negedge clk);
    end
    ia.out_ready = 1;
    @(negedge clk);
    chk("t2_issue_rd_en", ia.rd_en, 1);
    chk("t2_issue_w_addr", ia.w_addr, 3);
    chk("t2_issue_b_addr", ia.b_addr, 1);
    wait_for("t2_done", dn_a, d0 + 1);
    // abort during ISSUE of neuron 1
    qa.push_back(19);
    go(1, 0, 0);
    repeat (6) @(negedge clk);
    chk("t3_pre_rd_en", ia.rd_en, 1);
    chk("t3_pre_b_addr", ia.b_addr, 1);
    abort_a = 1;
    @(negedge clk);
    abort_a = 0;
    chk("t3_busy", busy_a, 0);
    chk("t3_rd_en", ia.rd_en, 0);
    chk("t3_valid", ia.out_valid, 0);
    d0 = dn_a;
    repeat (5) @(negedge clk);
    chk("t3_no_done", dn_a, d0);
    qa.push_back(19);
    qa.push_back(256);
    go(1, 0, 0);
    wait_for("t3_done", dn_a, d0 + 1);
    // async reset in DRAIN, then rerun with an ignored start while busy
    go(1, 0, 0);
    repeat (3) @(negedge clk);
    chk("t4_drain_rd_en", ia.rd_en, 0);
    chk("t4_drain_busy", busy_a, 1);
    #1 reset = 0;
    #1;
    chk("t4_rst_busy", busy_a, 0);
    chk("t4_rst_data", ia.out_data, 0);
    chk("t4_rst_w_addr", ia.w_addr, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    qa.push_back(19);
    qa.push_back(256);
    h0 = hs_a;
    d0 = dn_a;
    go(1, 0, 0);
    repeat (3) @(negedge clk);
    go(1, 0, 0);
    wait_for("t4_done", dn_a, d0 + 1);
    repeat (20) @(negedge clk);
    chk("t4_handshakes", hs_a - h0, 2);
    chk("t4_done_count", dn_a - d0, 1);
    // saturation high, plain and shifted
    act = '{8'sd127, 8'sd127, 8'sd127};
    wm[0] = 127;
    wm[1] = 127;
    wm[2] = 127;
    bm[0] = 127;
    qa.push_back(127);
    qa.push_back(256);
    qc.push_back(127);
    d0 = dn_a;
    h0 = dn_c;
    go(1, 0, 1);
    wait_for("t5_done_a", dn_a, d0 + 1);
    wait_for("t5_done_c", dn_c, h0 + 1);
    // negative bias clamps to zero
    act = '{8'sd0, 8'sd0, 8'sd0};
    bm[0] = -128;
    qa.push_back(0);
    qa.push_back(256);
    qc.push_back(0);
    d0 = dn_a;
    h0 = dn_c;
    go(1, 0, 1);
    wait_for("t6_done_a", dn_a, d0 + 1);
    wait_for("t6_done_c", dn_c, h0 + 1);
    // default-size layer against a reference sum
    for (int i = 0; i < 15; i++) begin
      r = $urandom_range(0, 15);
      act_b[i] = 8'(r - 4);
    end
    for (int i = 0; i < 480; i++) begin
      r = $urandom_range(0, 6);
      w_b[i] = 8'(r - 3);
    end
    for (int i = 0; i < 32; i++) begin
      r = $urandom_range(0, 20);
      b_b[i] = 8'(r - 10);
    end
    for (int n = 0; n < 32; n++) begin
      s = b_b[n];
      for (int k = 0; k < 15; k++) s += int'(act_b[k]) * int'(w_b[n * 15 + k]);
      qb.push_back(n * 256 + (s < 0 ? 0 : (s > 127 ? 127 : s)));
    end
    d0 = dn_b;
    go(0, 1, 0);
    wait_for("t7_done_b", dn_b, d0 + 1);
    repeat (3) @(negedge clk);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
